// File: rtl/lr35902_oam_scan.sv
// -----------------------------------------------------------------------------
// lr35902_oam_scan
//
// Mode-2 OAM search for the PPU. Walks the 40 OAM entries in fixed time
// (2 clk per entry, 80 clk per scan): phase 0 issues a word read of the Y/X
// pair, and phase 1 compares the registered Y against the latched line. Up to
// MAX_OBJ hits are stored in OAM order in a small buffer. The object fetcher
// reads that buffer by index.
//
// Optional feature macro: LR35902_OAM_SCAN_XHIT_EN. It adds an X-position
// matcher across the buffered entries.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               one-cycle pulse that starts a scan (ignored while busy)
//   ly                  line to scan for, sampled at start
//   obj_size            0 = 8-line objects, 1 = 16-line objects (live)
//   oam_adr, oam_read   OAM byte address (bit 0 always 0) and read strobe
//   oam_dout16          OAM word, {X, Y}, valid the cycle after oam_read
//   busy, done          scan in progress / one-cycle completion pulse
//   count               number of buffered objects, 0..MAX_OBJ
//   sel_idx             buffer read index
//   sel_x, sel_num      X and OAM entry number of buffer[sel_idx]
//   xpos (opt)          screen X being rendered
//   xhit, xhit_idx (opt) a buffered entry has X == xpos / lowest such index
// -----------------------------------------------------------------------------
module lr35902_oam_scan #(
  parameter int MAX_OBJ     = 10,
  parameter int NUM_ENTRIES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ly,
  input  logic        obj_size,
  output logic [7:0]  oam_adr,
  output logic        oam_read,
  input  logic [15:0] oam_dout16,
  output logic        busy,
  output logic        done,
  output logic [3:0]  count,
  input  logic [3:0]  sel_idx,
  output logic [7:0]  sel_x,
  output logic [5:0]  sel_num
`ifdef LR35902_OAM_SCAN_XHIT_EN
  ,
  input  logic [7:0]  xpos,
  output logic        xhit,
  output logic [3:0]  xhit_idx
`endif
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OBJ);
  localparam logic [5:0] LAST_N  = 6'(NUM_ENTRIES - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state, state_next;
  logic        phase;
  logic [5:0]  n;
  logic [7:0]  ly_q;
  logic        last;
  logic        wr_en;
  logic [7:0]  obj_x   [MAX_OBJ];
  logic [5:0]  obj_num [MAX_OBJ];

  // The object occupies the line when (ly + 16 - Y) mod 512 is below its
  // height. The 9-bit wrap keeps Y values near 255 from aliasing onto line 0.
  function automatic logic line_hit(input logic [7:0] line, input logic [7:0] y,
                                    input logic size16);
    logic [8:0] d;
    d = {1'b0, line} + 9'd16 - {1'b0, y};
    return size16 ? (d < 9'd16) : (d < 9'd8);
  endfunction

  assign busy     = (state == SCAN);
  assign oam_read = (state == SCAN) && !phase;
  assign oam_adr  = {n, 2'b00};
  assign last     = (state == SCAN) && phase && (n == LAST_N);
  assign wr_en    = (state == SCAN) && phase && (count < MAX_CNT) &&
                    line_hit(ly_q, oam_dout16[7:0], obj_size);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      phase <= 1'b0;
      n     <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= last;
      if (state == IDLE && start) begin
        phase <= 1'b0;
        n     <= '0;
        count <= '0;
      end else if (state == SCAN) begin
        phase <= ~phase;
        if (phase) n <= last ? 6'd0 : n + 6'd1;
        if (wr_en) count <= count + 4'd1;
      end
    end
  end

  // Compare stage: capture the line and store hits (data path, no reset)
  always_ff @(posedge clk) begin
    if (state == IDLE && start) ly_q <= ly;
    if (wr_en) begin
      obj_x[count]   <= oam_dout16[15:8];
      obj_num[count] <= n;
    end
  end

  always_comb begin
    sel_x   = '0;
    sel_num = '0;
    if (sel_idx < MAX_CNT) begin
      sel_x   = obj_x[sel_idx];
      sel_num = obj_num[sel_idx];
    end
  end

`ifdef LR35902_OAM_SCAN_XHIT_EN
  logic       xhit_c, xhit_q;
  logic [3:0] xidx_c, xidx_q;

  // Scan from the top down so the lowest matching index wins.
  always_comb begin
    xhit_c = 1'b0;
    xidx_c = '0;
    for (int i = MAX_OBJ - 1; i >= 0; i--) begin
      if (4'(i) < count && obj_x[i] == xpos) begin
        xhit_c = 1'b1;
        xidx_c = 4'(i);
      end
    end
  end

  // Match stage: registered result, suppressed while the buffer is filling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xhit_q <= 1'b0;
      xidx_q <= '0;
    end else begin
      xhit_q <= xhit_c;
      xidx_q <= xidx_c;
    end
  end

  assign xhit     = xhit_q && !busy;
  assign xhit_idx = busy ? 4'd0 : xidx_q;
`endif

endmodule

// File: doc/lr35902_oam_scan.md
Name: lr35902_oam_scan

Overview:
- Mode-2 OAM search stage of the PPU.
- Sits directly downstream of the OAM RAM: issues word reads, consumes the registered 16-bit Y/X pair, and selects up to 10 objects overlapping the current line.
- Results go into a small buffer that the object fetcher reads by index.
- One scan takes exactly 80 clk cycles, 2 per OAM entry, 40 entries.

Parameters:
- MAX_OBJ, 10, buffer depth (max objects per line).
- NUM_ENTRIES, 40, OAM entries scanned.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a scan for line ly.
- ly  in  8  current line, sampled at start.
- obj_size  in  1  0 = 8-line objects, 1 = 16-line objects; sampled live at each compare.
- oam_adr  out  8  byte address to OAM; bit 0 always 0.
- oam_read  out  1  OAM read strobe.
- oam_dout16  in  16  OAM registered word: [7:0] = Y, [15:8] = X; valid the cycle after oam_read.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the scan completes.
- count  out  4  number of objects buffered, 0..MAX_OBJ.
- sel_idx  in  4  buffer read index.
- sel_x  out  8  X of entry sel_idx (combinational read).
- sel_num  out  6  OAM entry number of entry sel_idx.

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, count=0, oam_read=0, oam_adr=0, entry counter 0. Buffer contents are don't-care.
- States: IDLE and SCAN.
- IDLE → SCAN on start. Latch ly into ly_q, clear count, entry counter n=0, phase=0.
- SCAN, phase 0: oam_read=1, oam_adr={n,2'b00}.
- SCAN, phase 1: oam_read=0, oam_adr held; oam_dout16 is valid. Compute:
  - d = ({1'b0,ly_q} + 9'd16 - {1'b0,Y}) mod 512;
  - h = obj_size ? 16 : 8;
  - hit = (d < h).
- On a hit with count < MAX_OBJ: write buffer[count] = {X, n} and increment count. Hits when count == MAX_OBJ are dropped. The scan still continues, so timing stays fixed.
- At the end of phase 1, n increments and phase returns to 0.
- After phase 1 of n = 39 (cycle 80 after start):
  - done=1 for one cycle;
  - busy=0;
  - next state IDLE;
  - count and buffer hold until the next start.
- busy=1 from the cycle after start through the cycle that ends entry 39.
- start while in SCAN is ignored; no restart.
- start in the same cycle as done-cycle completion: that cycle ends the scan; start is ignored. Controllers must pulse start at least one cycle after done.
- Buffer preserves OAM order: lowest entry number at index 0.
- sel_idx ≥ count returns stale/undefined data; the consumer must gate with count.
- Reset asserted mid-scan aborts immediately: count=0, no done pulse.
- X=0 or X≥168 is still buffered; off-screen culling belongs to the fetcher.
- Y wrap example: ly=0, Y=255 gives d=273 → no hit. ly=0, Y=9 gives d=7 → hit at size 8.

Optional Feature:
- Macro: LR35902_OAM_SCAN_XHIT_EN.
- When defined, adds ports:
  - xpos  in  8  screen X being rendered;
  - xhit  out  1  some entry < count has X == xpos;
  - xhit_idx  out  4  lowest such buffer index.
- xhit and xhit_idx are registered, valid one clk after xpos changes. Both are forced to 0 while busy.
- When undefined, these ports are absent and the comparator logic is not built.

Test Plan:
- Only OAM entry 5 has Y=16, X=8 (all others Y=0); ly=0, obj_size=0; pulse start → done exactly 80 cycles later, count=1, sel_idx=0 gives sel_x=8, sel_num=5.
- Entries 0..39 all Y=20; ly=10, obj_size=0 → count=10, sel_num[i]=i for i=0..9, done still at cycle 80.
- Entry 3 has Y=10; ly=9: obj_size=0 gives d=15 → no hit (count=0); obj_size=1 → hit (count=1).
- Check the oam_read/oam_adr sequence: reads on cycles 1,3,5,… with addresses 0x00, 0x04, … 0x9C; second start pulse during the scan has no effect.
- Assert reset at cycle 30 of a scan → busy=0, count=0 immediately; no done pulse; a new start rescans correctly.
- With LR35902_OAM_SCAN_XHIT_EN: buffered X values {8,20,8}, xpos=8 → xhit=1, xhit_idx=0; xpos=9 → xhit=0.
